cnt_match_irq: RTL and testbench
================================

CNT_MATCH_IRQ -- requirements
Module: cnt_match_irq

Interface
REQ-001 Parameter BITS, default 32: width of count, compare, timestamp and bus data.
REQ-002 Parameter DEPTH, default 4: capture FIFO entries, power of two, minimum 2.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 count  input  BITS  live value from upstream counter, sampled every cycle.
REQ-006 valid  input  1  bus request.
REQ-007 addr  input  2  word select: 0 CTRL, 1 COMPARE, 2 STATUS, 3 CAPTURE.
REQ-008 wstrb  input  4  byte write enables; all zero means read.
REQ-009 wdata  input  BITS  write data.
REQ-010 ready  output  1  one-cycle acknowledge pulse.
REQ-011 rdata  output  BITS  read data, valid while ready=1.
REQ-012 irq  output  1  level interrupt to the user_irq line.

Function
REQ-013 Handshake: ready SHALL be 1 exactly one cycle after a cycle with valid=1 and ready=0; ready SHALL never be 1 on two consecutive cycles.
REQ-014 Writes and pops SHALL take effect on the same edge that raises ready; rdata SHALL be registered on that edge.
REQ-015 CTRL: bit0 EN, bit1 IRQ_EN, bit2 ONESHOT (EN self-clears after the first match); other bits read 0.
REQ-016 COMPARE: byte-lane writable via wstrb.
REQ-017 STATUS: bit0 PEND (write-1-clear), bit1 OVF (write-1-clear), bits[7:4] FIFO level; other bits read 0.
REQ-018 CAPTURE: read returns the head entry and pops it; read when empty returns 0 and changes nothing; writes are ignored.
REQ-019 Internal BITS-wide timestamp increments every cycle after reset and wraps from all-ones to 0.
REQ-020 Match event: EN=1 and count==COMPARE this cycle, and no match on the previous cycle (rising edge); a held count SHALL produce one event only.
REQ-021 On a match event, PEND SHALL set and the timestamp SHALL be pushed to the capture store.
REQ-022 Push when full without a simultaneous pop SHALL drop the new entry, keep the existing entries and set OVF.
REQ-023 Push and pop in the same cycle when full SHALL both succeed with no OVF.
REQ-024 W1C of PEND in the same cycle as a match event: set wins.
REQ-025 irq SHALL equal PEND AND IRQ_EN, registered, asserting the cycle after PEND sets.
REQ-026 Writing COMPARE SHALL clear the match-edge history so that an immediately equal count produces an event.

Reset
REQ-027 On reset: ready=0, rdata=0, irq=0, CTRL=0, COMPARE=0, PEND=0, OVF=0, FIFO empty, timestamp=0, match history=0.
REQ-028 Reset asserted while a request is pending SHALL abort it; no ack SHALL follow reset release.

Configuration
REQ-029 Macro CNT_MATCH_FIFO_EN defined: the capture store is a DEPTH-entry FIFO as in REQ-018 to REQ-023.
REQ-030 CNT_MATCH_FIFO_EN undefined: the capture store is a single register with a valid flag; push when valid overwrites the register and sets OVF; level reads 0 or 1.

Structure
REQ-031 Package cnt_match_pkg SHALL hold the register offsets, CTRL/STATUS bit positions and the default DEPTH.
REQ-032 The FIFO SHALL be sub-module cnt_match_fifo (push, pop, full, empty, level), instantiated only under CNT_MATCH_FIFO_EN.

Verification
REQ-033 Write COMPARE=0x10, CTRL=0x3; ramp count 0x0E..0x12 -> irq rises the cycle after PEND sets; exactly one capture entry.
REQ-034 Hold count=0x10 for 20 cycles -> one event; STATUS[7:4]=1.
REQ-035 Trigger 5 matches with DEPTH=4 and no reads -> level=4, OVF=1; 4 CAPTURE reads return the first 4 timestamps in order; a 5th read returns 0.
REQ-036 Write STATUS=0x1 on the same cycle as a match -> PEND stays 1.
REQ-037 Set CTRL=0x5 and match twice -> one capture; CTRL reads 0x4.
REQ-038 Assert reset on the cycle after valid -> no ready pulse; all registers read 0 afterwards.

Source files
------------

// File: rtl/cnt_match_pkg.sv
// cnt_match_pkg: shared register map, CTRL/STATUS bit positions and default capture depth
package cnt_match_pkg;
  localparam int DEPTH_DEF = 4;
  typedef enum logic [1:0] {REG_CTRL, REG_COMPARE, REG_STATUS, REG_CAPTURE} reg_e;
  localparam int C_EN = 0;
  localparam int C_IRQ_EN = 1;
  localparam int C_ONESHOT = 2;
  localparam int S_PEND = 0;
  localparam int S_OVF = 1;
  localparam int S_LVL = 4;
endpackage

// File: rtl/cnt_match_irq_if.sv
// cnt_match_irq_if: single-cycle register bus (valid/addr/wstrb/wdata request, ready/rdata acknowledge)
interface cnt_match_irq_if #(parameter int BITS = 32);
  logic            valid;
  logic [1:0]      addr;
  logic [3:0]      wstrb;
  logic [BITS-1:0] wdata;
  logic            ready;
  logic [BITS-1:0] rdata;
  modport master (output valid, addr, wstrb, wdata, input ready, rdata);
  modport slave (input valid, addr, wstrb, wdata, output ready, rdata);
endinterface

// File: rtl/cnt_match_fifo.sv
// cnt_match_fifo: DEPTH-entry capture FIFO; a push when full only lands if a pop frees a slot on the same edge
// Ports: clk, reset (sync, active-high), push/din, pop/dout (head), full, empty, level (entry count)
module cnt_match_fifo #(
  parameter int BITS = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [BITS-1:0]        din,
  output logic [BITS-1:0]        dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic do_push, do_pop;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      rp <= '0;
      wp <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/cnt_match_irq.sv
// cnt_match_irq: counter compare unit with timestamp capture store and level interrupt
// Ports: clk, reset (sync, active-high), count (live counter value), bus (register slave), irq (level interrupt)
// Macro CNT_MATCH_FIFO_EN: capture store is a DEPTH-entry FIFO; otherwise a single overwriting register
module cnt_match_irq
  import cnt_match_pkg::*;
#(
  parameter int BITS = 32,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] count,
  cnt_match_irq_if.slave  bus,
  output logic            irq
);
  logic [2:0] ctrl;
  logic [BITS-1:0] cmp, ts, mask, cap_data, stat, rd_val;
  logic [$clog2(DEPTH):0] level;
  logic [3:0] lvl;
  logic pend, ovf, hit, hit_q, ev, ovf_set, req, wr, rd, pop, full, cap_empty, w_ctrl, w_cmp, w_stat;
  assign req = bus.valid && !bus.ready;
  assign wr = req && |bus.wstrb;
  assign rd = req && !(|bus.wstrb);
  assign pop = rd && bus.addr == REG_CAPTURE;
  assign w_ctrl = wr && bus.addr == REG_CTRL;
  assign w_cmp = wr && bus.addr == REG_COMPARE;
  assign w_stat = wr && bus.addr == REG_STATUS;
  for (genvar i = 0; i < BITS; i++) begin : g_mask
    assign mask[i] = i < 32 && bus.wstrb[(i / 8) % 4];
  end
  // hit_q remembers last cycle's equality so a held count raises only one event
  assign hit = ctrl[C_EN] && count == cmp;
  assign ev = hit && !hit_q;
  // a simultaneous pop always frees room, so only an unpopped full store overflows
  assign ovf_set = ev && full && !pop;
  assign lvl = 4'(level);
`ifdef CNT_MATCH_FIFO_EN
  cnt_match_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(ev),
    .pop(pop),
    .din(ts),
    .dout(cap_data),
    .full(full),
    .empty(cap_empty),
    .level(level)
  );
`else
  logic cap_valid;
  assign full = cap_valid;
  assign cap_empty = !cap_valid;
  assign level = {{$clog2(DEPTH){1'b0}}, cap_valid};
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid <= 1'b0;
      cap_data <= '0;
    end else if (ev) begin
      cap_valid <= 1'b1;
      cap_data <= ts;
    end else if (pop) cap_valid <= 1'b0;
  end
`endif
  always_comb begin
    stat = '0;
    stat[S_PEND] = pend;
    stat[S_OVF] = ovf;
    stat[S_LVL +: 4] = lvl;
  end
  assign rd_val = bus.addr == REG_CTRL ? BITS'(ctrl) : bus.addr == REG_COMPARE ? cmp :
                  bus.addr == REG_STATUS ? stat : cap_empty ? '0 : cap_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
      cmp <= '0;
      ts <= '0;
      pend <= 1'b0;
      ovf <= 1'b0;
      hit_q <= 1'b0;
      irq <= 1'b0;
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      ts <= ts + 1'b1;
      bus.ready <= req;
      bus.rdata <= rd ? rd_val : '0;
      irq <= pend & ctrl[C_IRQ_EN];
      hit_q <= w_cmp ? 1'b0 : hit;
      if (w_ctrl) ctrl <= ctrl & ~mask[2:0] | bus.wdata[2:0] & mask[2:0];
      if (ev && ctrl[C_ONESHOT]) ctrl[C_EN] <= 1'b0;
      if (w_cmp) cmp <= cmp & ~mask | bus.wdata & mask;
      pend <= ev | pend & !(w_stat && bus.wdata[S_PEND] && mask[S_PEND]);
      ovf <= ovf_set | ovf & !(w_stat && bus.wdata[S_OVF] && mask[S_OVF]);
    end
  end
endmodule

// File: tb/tb_cnt_match_irq.sv
// tb_cnt_match_irq: directed scenarios plus randomized traffic checked against a queue-based reference model
module tb_cnt_match_irq;
`ifdef CNT_MATCH_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] cnt = '0;
  logic irq;
  int checks = 0;
  int errors = 0;
  logic [31:0] r;
  cnt_match_irq_if #(.BITS(32)) bus_if ();
  cnt_match_irq dut (.clk(clk), .reset(reset), .count(cnt), .bus(bus_if), .irq(irq));
  always #5 clk = ~clk;
  logic [2:0] m_ctrl;
  logic [31:0] m_cmp, m_ts, m_rdata, mrv, mwm;
  logic m_pend, m_ovf, m_prev, m_ready, m_irq, mreq, mwr, mrd, mhit, mev, mos, movf;
  logic [31:0] m_q[$];
  always @(posedge clk) begin
    if (reset) begin
      m_ctrl = 0; m_cmp = 0; m_ts = 0; m_pend = 0; m_ovf = 0; m_prev = 0;
      m_ready = 0; m_rdata = 0; m_irq = 0; m_q.delete();
    end else begin
      mreq = bus_if.valid && !m_ready;
      mwr = mreq && bus_if.wstrb != 0;
      mrd = mreq && bus_if.wstrb == 0;
      mhit = m_ctrl[0] && cnt == m_cmp;
      mev = mhit && !m_prev;
      mos = m_ctrl[2];
      for (int b = 0; b < 4; b++) mwm[8*b +: 8] = {8{bus_if.wstrb[b]}};
      case (bus_if.addr)
        2'd0: mrv = {29'd0, m_ctrl};
        2'd1: mrv = m_cmp;
        2'd2: mrv = {24'd0, 4'(m_q.size()), 2'b00, m_ovf, m_pend};
        default: mrv = m_q.size() > 0 ? m_q[0] : 32'd0;
      endcase
      m_irq = m_pend && m_ctrl[1];
      m_ready = mreq;
      m_rdata = mrd ? mrv : 32'd0;
      if (mrd && bus_if.addr == 2'd3 && m_q.size() > 0) void'(m_q.pop_front());
      movf = 0;
      if (mev) begin
        if (m_q.size() < CAP) m_q.push_back(m_ts);
        else begin
          movf = 1;
          if (CAP == 1) m_q[0] = m_ts;
        end
      end
      if (mwr && bus_if.addr == 2'd0) m_ctrl = (m_ctrl & ~mwm[2:0]) | (bus_if.wdata[2:0] & mwm[2:0]);
      if (mev && mos) m_ctrl[0] = 0;
      if (mwr && bus_if.addr == 2'd2 && bus_if.wstrb[0]) begin
        if (bus_if.wdata[0]) m_pend = 0;
        if (bus_if.wdata[1]) m_ovf = 0;
      end
      if (mev) m_pend = 1;
      if (movf) m_ovf = 1;
      if (mwr && bus_if.addr == 2'd1) begin
        m_cmp = (m_cmp & ~mwm) | (bus_if.wdata & mwm);
        m_prev = 0;
      end else m_prev = mhit;
      m_ts = m_ts + 1;
    end
  end
  task automatic bus(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d, output logic [31:0] q);
    @(negedge clk);
    bus_if.valid = 1; bus_if.addr = a; bus_if.wstrb = s; bus_if.wdata = d;
    @(negedge clk);
    q = bus_if.rdata;
    bus_if.valid = 0; bus_if.wstrb = 0;
  endtask
  task automatic do_reset;
    @(negedge clk);
    reset = 1; bus_if.valid = 0; bus_if.addr = 0; bus_if.wstrb = 0; bus_if.wdata = 0; cnt = 0;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask
  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++; if (bus_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus_if.ready); end
    checks++; if (bus_if.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus_if.rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
    for (int a = 0; a < 4; a++) begin
      bus(2'(a), 4'h0, 32'd0, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", a, r); end
    end
  endtask
  task automatic test_back_to_back;
    do_reset();
    @(negedge clk);
    bus_if.valid = 1; bus_if.addr = 2'd1; bus_if.wstrb = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (bus_if.ready !== 1'(i % 2 == 0)) begin errors++; $display("FAIL b2b_ready%0d got %b exp %b", i, bus_if.ready, i % 2 == 0); end
    end
    bus_if.valid = 0;
  endtask
  task automatic test_ramp;
    logic [31:0] stamp;
    do_reset();
    bus(2'd1, 4'hf, 32'h10, r);
    bus(2'd0, 4'hf, 32'h3, r);
    for (int c = 'h0e; c <= 'h12; c++) begin
      @(negedge clk);
      if (c == 'h11) begin checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ramp_irq_early got %b exp 0", irq); end end
      if (c == 'h12) begin checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ramp_irq_rise got %b exp 1", irq); end end
      cnt = 32'(c);
      if (c == 'h10) stamp = m_ts;
    end
    bus(2'd2, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h11) begin errors++; $display("FAIL ramp_status got %h exp 11", r); end
    bus(2'd3, 4'h0, 32'd0, r);
    checks++; if (r !== stamp) begin errors++; $display("FAIL ramp_capture got %h exp %h", r, stamp); end
    bus(2'd3, 4'h0, 32'd0, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL ramp_capture_empty got %h exp 0", r); end
  endtask
  task automatic test_hold;
    logic [31:0] stamp;
    do_reset();
    bus(2'd1, 4'hf, 32'h10, r);
    bus(2'd0, 4'hf, 32'h1, r);
    @(negedge clk);
    cnt = 32'h10; stamp = m_ts;
    repeat (19) @(negedge clk);
    bus(2'd2, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h11) begin errors++; $display("FAIL hold_status got %h exp 11", r); end
    bus(2'd3, 4'h0, 32'd0, r);
    checks++; if (r !== stamp) begin errors++; $display("FAIL hold_capture got %h exp %h", r, stamp); end
    bus(2'd3, 4'h0, 32'd0, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL hold_single got %h exp 0", r); end
  endtask
  task automatic test_overflow;
    logic [31:0] st[5];
    do_reset();
    bus(2'd1, 4'hf, 32'h10, r);
    bus(2'd0, 4'hf, 32'h1, r);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cnt = 32'h10; st[k] = m_ts;
      @(negedge clk);
      cnt = 32'h11;
    end
    bus(2'd2, 4'h0, 32'd0, r);
    checks++; if (r !== (CAP == 4 ? 32'h43 : 32'h13)) begin errors++; $display("FAIL ovf_status got %h exp %h", r, CAP == 4 ? 32'h43 : 32'h13); end
    for (int k = 0; k < CAP; k++) begin
      bus(2'd3, 4'h0, 32'd0, r);
      checks++; if (r !== (CAP == 4 ? st[k] : st[4])) begin errors++; $display("FAIL ovf_capture%0d got %h exp %h", k, r, CAP == 4 ? st[k] : st[4]); end
    end
    bus(2'd3, 4'h0, 32'd0, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL ovf_drained got %h exp 0", r); end
    bus(2'd2, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h3) begin errors++; $display("FAIL ovf_status_empty got %h exp 3", r); end
    bus(2'd2, 4'h1, 32'h2, r);
    bus(2'd2, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL ovf_w1c got %h exp 1", r); end
  endtask
  task automatic test_w1c_race;
    do_reset();
    cnt = 32'h11;
    bus(2'd1, 4'hf, 32'h10, r);
    bus(2'd0, 4'hf, 32'h3, r);
    @(negedge clk);
    cnt = 32'h10; bus_if.valid = 1; bus_if.addr = 2'd2; bus_if.wstrb = 4'h1; bus_if.wdata = 32'h1;
    @(negedge clk);
    checks++; if (bus_if.ready !== 1'b1) begin errors++; $display("FAIL race_ack got %b exp 1", bus_if.ready); end
    bus_if.valid = 0; bus_if.wstrb = 0; cnt = 32'h20;
    bus(2'd2, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h11) begin errors++; $display("FAIL race_pend got %h exp 11", r); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_irq got %b exp 1", irq); end
    bus(2'd2, 4'h1, 32'h1, r);
    bus(2'd2, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h10) begin errors++; $display("FAIL w1c_pend got %h exp 10", r); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b exp 0", irq); end
  endtask
  task automatic test_oneshot;
    logic [31:0] stamp;
    do_reset();
    bus(2'd1, 4'hf, 32'h10, r);
    bus(2'd0, 4'hf, 32'h5, r);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      cnt = 32'h10;
      if (k == 0) stamp = m_ts;
      @(negedge clk);
      cnt = 32'h11;
    end
    bus(2'd0, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h4) begin errors++; $display("FAIL oneshot_ctrl got %h exp 4", r); end
    bus(2'd2, 4'h0, 32'd0, r);
    checks++; if (r !== 32'h11) begin errors++; $display("FAIL oneshot_status got %h exp 11", r); end
    bus(2'd3, 4'h0, 32'd0, r);
    checks++; if (r !== stamp) begin errors++; $display("FAIL oneshot_capture got %h exp %h", r, stamp); end
  endtask
  task automatic test_reset_abort;
    do_reset();
    bus(2'd1, 4'hf, 32'h10, r);
    bus(2'd0, 4'hf, 32'h3, r);
    @(negedge clk);
    cnt = 32'h10;
    @(negedge clk);
    cnt = 32'h0; bus_if.valid = 1; bus_if.addr = 2'd0; bus_if.wstrb = 0; reset = 1;
    @(negedge clk);
    bus_if.valid = 0;
    checks++; if (bus_if.ready !== 1'b0) begin errors++; $display("FAIL abort_ready_in got %b exp 0", bus_if.ready); end
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus_if.ready !== 1'b0) begin errors++; $display("FAIL abort_ready%0d got %b exp 0", i, bus_if.ready); end
    end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL abort_irq got %b exp 0", irq); end
    for (int a = 0; a < 4; a++) begin
      bus(2'(a), 4'h0, 32'd0, r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL abort_reg%0d got %h exp 0", a, r); end
    end
  endtask
  task automatic test_random;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++; if (bus_if.ready !== m_ready) begin errors++; $display("FAIL rand_ready@%0d got %b exp %b", i, bus_if.ready, m_ready); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq@%0d got %b exp %b", i, irq, m_irq); end
      if (m_ready) begin
        checks++; if (bus_if.rdata !== m_rdata) begin errors++; $display("FAIL rand_rdata@%0d got %h exp %h", i, bus_if.rdata, m_rdata); end
      end
      bus_if.valid = 1'($urandom_range(0, 1));
      bus_if.addr = 2'($urandom_range(0, 3));
      bus_if.wstrb = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'h0;
      bus_if.wdata = 32'($urandom_range(0, 7));
      cnt = 32'($urandom_range(0, 3));
    end
    bus_if.valid = 0;
  endtask
  initial begin
    bus_if.valid = 0; bus_if.addr = 0; bus_if.wstrb = 0; bus_if.wdata = 0;
    test_reset();
    test_back_to_back();
    test_ramp();
    test_hold();
    test_overflow();
    test_w1c_race();
    test_oneshot();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
